code_mem_ctrl: RTL

- Parametrised code/data memory for the MCS8 core and its benches. It is the next generation of the fixed 14-bit-address, 8-bit-data combinational code ROM.
- Adds configurable address/data width and depth, a programmable wait-state generator, and a REQ/ACK handshake so the core's fetch stage can be exercised under stalls.
- Adds a write path so benches and boot logic can load code at run time.
- Sits between the CPU instruction port and the bench clock/reset generator.

---
 rtl/mcs8_mem_pkg.sv | 7 +
 rtl/mem_wait_timer.sv | 17 +
 rtl/code_mem_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/mcs8_mem_pkg.sv
// mcs8_mem_pkg: shared state encoding and default geometry for the MCS8 code memory.
package mcs8_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_e;
  localparam int MCS8_AW = 14;
  localparam int MCS8_DW = 8;
  localparam logic [7:0] MCS8_FILL = 8'hFF;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: loadable down-counter; done flags the last wait cycle.
module mem_wait_timer #(
  parameter int WSW = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic [WSW-1:0] value_i,
  output logic           done_o
);
  logic [WSW-1:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else if (load_i) cnt_q <= value_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign done_o = cnt_q == WSW'(1);
endmodule

// File: rtl/code_mem_ctrl.sv
// code_mem_ctrl: parametrised code/data memory with wait states and REQ/ACK handshake.
// Define CODE_MEM_STATS_EN to add saturating access/stall counters.
module code_mem_ctrl
  import mcs8_mem_pkg::*;
#(
  parameter int AW = MCS8_AW,
  parameter int DW = MCS8_DW,
  parameter int DEPTH = 16384,
  parameter int WSW = 4,
  parameter logic [DW-1:0] FILL = DW'(MCS8_FILL)
) (
  input  logic           CLK_I,
  input  logic           nRST_I,
  input  logic           REQ_I,
  input  logic           WE_I,
  input  logic [AW-1:0]  ADDR_I,
  input  logic [DW-1:0]  WDAT_I,
  input  logic [WSW-1:0] WAIT_I,
  output logic [DW-1:0]  DAT_O,
  output logic           ACK_O,
  output logic           BUSY_O
`ifdef CODE_MEM_STATS_EN
  ,
  output logic [31:0]    ACC_CNT_O,
  output logic [31:0]    STALL_CNT_O
`endif
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, a_addr;
  logic [DW-1:0] wdat_q, a_wdat, dat_q;
  logic we_q, a_we, start, go, hit, done;
  logic [DW-1:0] mem [DEPTH];
  // Zero-wait accesses complete on the sampling edge, so bypass the latches in IDLE.
  always_comb begin
    start = state_q == IDLE && REQ_I;
    a_addr = state_q == IDLE ? ADDR_I : addr_q;
    a_we = state_q == IDLE ? WE_I : we_q;
    a_wdat = state_q == IDLE ? WDAT_I : wdat_q;
    hit = {1'b0, a_addr} < (AW+1)'(DEPTH);
    state_d = state_q == IDLE ? (REQ_I ? (|WAIT_I ? WAIT : ACK) : IDLE)
            : state_q == WAIT ? (done ? ACK : WAIT) : IDLE;
    go = state_d == ACK;
  end
  mem_wait_timer #(.WSW(WSW)) u_timer (
    .clk_i(CLK_I), .rst_ni(nRST_I), .load_i(start), .value_i(WAIT_I), .done_o(done)
  );
  always_ff @(posedge CLK_I or negedge nRST_I)
    if (!nRST_I) begin
      state_q <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      wdat_q <= '0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q <= ADDR_I;
        we_q <= WE_I;
        wdat_q <= WDAT_I;
      end
      if (go && !a_we) dat_q <= hit ? mem[a_addr[IW-1:0]] : FILL;
    end
  always_ff @(posedge CLK_I)
    if (go && a_we && hit && nRST_I) mem[a_addr[IW-1:0]] <= a_wdat;
  assign DAT_O = dat_q;
  assign ACK_O = state_q == ACK;
  assign BUSY_O = state_q != IDLE;
`ifdef CODE_MEM_STATS_EN
  logic [31:0] acc_q, stall_q;
  always_ff @(posedge CLK_I or negedge nRST_I)
    if (!nRST_I) begin
      acc_q <= '0;
      stall_q <= '0;
    end else begin
      if (state_q == ACK && ~&acc_q) acc_q <= acc_q + 1'b1;
      if (state_q == WAIT && ~&stall_q) stall_q <= stall_q + 1'b1;
    end
  assign ACC_CNT_O = acc_q;
  assign STALL_CNT_O = stall_q;
`endif
endmodule
